// File: rtl/conversor_bin_bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM state encodings,
// nibble-adjust constants and a helper that sizes the iteration counter.
package conversor_bin_bcd_pkg;

  // 2'd3 is not a legal state; the FSM sends it back to OCIOSO.
  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    DESLOCA = 2'd1,
    FIM     = 2'd2
  } estado_t;

  // A BCD nibble at or above the threshold gets the offset added before the shift.
  localparam logic [3:0] BCD_AJUSTE_LIMIAR = 4'd5;
  localparam logic [3:0] BCD_AJUSTE_SOMA   = 4'd3;

  // Bits needed for a counter that must hold the value 'largura'.
  function automatic int largura_contador(input int largura);
    return $clog2(largura + 1);
  endfunction

endpackage

// File: rtl/conversor_bin_bcd_if.sv
// Request/result bundle between a value producer and the BCD converter.
// Optional macro CONV_BCD_APAGA_EN adds the leading-zero blanking vector 'apaga'.
interface conversor_bin_bcd_if #(
  parameter int LARGURA = 8,
  parameter int DIGITOS = 3
);

  logic                   inicio;
  logic [LARGURA-1:0]     entrada;
  logic                   ocupado;
  logic                   pronto;
  logic [4*DIGITOS-1:0]   saida;
`ifdef CONV_BCD_APAGA_EN
  logic [DIGITOS-1:0]     apaga;
`endif

`ifdef CONV_BCD_APAGA_EN
  modport master (output inicio, entrada, input ocupado, pronto, saida, apaga);
  modport slave  (input inicio, entrada, output ocupado, pronto, saida, apaga);
`else
  modport master (output inicio, entrada, input ocupado, pronto, saida);
  modport slave  (input inicio, entrada, output ocupado, pronto, saida);
`endif

endinterface

// File: rtl/conversor_bin_bcd_ajuste_bcd.sv
// Combinational double-dabble cell: a BCD nibble of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module ajuste_bcd
  import conversor_bin_bcd_pkg::*;
(
  input  logic [3:0] digito,
  output logic [3:0] ajustado
);

  // Add-3 when the nibble would reach 10 or more after doubling; 4-bit wrap is harmless.
  assign ajustado = (digito >= BCD_AJUSTE_LIMIAR) ? digito + BCD_AJUSTE_SOMA : digito;

endmodule

// File: rtl/conversor_bin_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// inicio accepted in OCIOSO -> LARGURA cycles in DESLOCA -> one FIM cycle with pronto.
// saida is loaded on the edge that enters FIM, so it is valid while pronto is high
// and holds the previous result for the whole conversion.
// Optional macro CONV_BCD_APAGA_EN adds the 'apaga' leading-zero blanking output.
module conversor_bin_bcd
  import conversor_bin_bcd_pkg::*;
#(
  parameter int LARGURA = 8,
  parameter int DIGITOS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  conversor_bin_bcd_if.slave   bus
);

  localparam int CW = largura_contador(LARGURA);

  estado_t               estado;
  estado_t               prox_estado;
  logic [LARGURA-1:0]    bin_q;
  logic [4*DIGITOS-1:0]  bcd_q;
  logic [4*DIGITOS-1:0]  bcd_adj;
  logic [4*DIGITOS-1:0]  bcd_shift;
  logic [CW-1:0]         cnt_q;
  logic                  aceita;
  logic                  ultimo;

  // One adjust cell per BCD digit of the accumulator.
  for (genvar g = 0; g < DIGITOS; g++) begin : g_ajuste
    ajuste_bcd u_ajuste (
      .digito   (bcd_q[4*g +: 4]),
      .ajustado (bcd_adj[4*g +: 4])
    );
  end

  // Adjusted accumulator shifted left, taking in the binary MSB; overflow bits are dropped.
  assign bcd_shift = (bcd_adj << 1) | {{(4*DIGITOS-1){1'b0}}, bin_q[LARGURA-1]};
  assign aceita    = (estado == OCIOSO) && bus.inicio;
  assign ultimo    = (estado == DESLOCA) && (cnt_q == CW'(1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) estado <= OCIOSO;
    else     estado <= prox_estado;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first, so no path leaves prox_estado unassigned (no latch).
    prox_estado = OCIOSO;
    case (estado)
      OCIOSO:  prox_estado = bus.inicio ? DESLOCA : OCIOSO;
      DESLOCA: prox_estado = (cnt_q == CW'(1)) ? FIM : DESLOCA;
      FIM:     prox_estado = OCIOSO;
      default: prox_estado = OCIOSO;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    bus.ocupado = (estado == DESLOCA) || (estado == FIM);
    bus.pronto  = (estado == FIM);
  end

  // Shift datapath: load on an accepted request, shift one bit per DESLOCA cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (aceita) begin
      bin_q <= bus.entrada;
      bcd_q <= '0;
      cnt_q <= CW'(LARGURA);
    end else if (estado == DESLOCA) begin
      bin_q <= bin_q << 1;
      bcd_q <= bcd_shift;
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // Result register: updated only when the last shift completes, so displays never see partial values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         bus.saida <= '0;
    else if (ultimo) bus.saida <= bcd_shift;
  end

`ifdef CONV_BCD_APAGA_EN
  logic [DIGITOS-1:0] apaga_prox;
  logic               zeros_acima;

  // Digit k (k >= 1) is blanked when it and every higher digit are zero; digit 0 always shows.
  always_comb begin
    apaga_prox  = '0;
    zeros_acima = 1'b1;
    for (int k = DIGITOS - 1; k >= 1; k--) begin
      zeros_acima   = zeros_acima && (bcd_shift[4*k +: 4] == 4'd0);
      apaga_prox[k] = zeros_acima;
    end
  end

  // Blanking mask is registered together with saida.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         bus.apaga <= '0;
    else if (ultimo) bus.apaga <= apaga_prox;
  end
`endif

endmodule

// File: tb/tb_conversor_bin_bcd.sv
// Directed self-checking bench for conversor_bin_bcd: an 8-bit/3-digit instance
// for latency, handshake and reset behaviour, and a 16-bit/5-digit instance for width.
// Blanking checks are compiled in when CONV_BCD_APAGA_EN is defined.
module tb_conversor_bin_bcd;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [11:0] prev8  = 12'h000;
  logic [19:0] prev16 = 20'h00000;

  always #5 clk = ~clk;

  conversor_bin_bcd_if #(.LARGURA(8),  .DIGITOS(3)) bus8 ();
  conversor_bin_bcd_if #(.LARGURA(16), .DIGITOS(5)) bus16 ();

  conversor_bin_bcd #(.LARGURA(8), .DIGITOS(3)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  conversor_bin_bcd #(.LARGURA(16), .DIGITOS(5)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on the 8-bit instance and follow it cycle by cycle to the
  // first idle cycle after FIM, where the next request may be issued.
  task automatic run8(input logic [7:0] v, input logic [11:0] esperado, input string tag);
    bus8.entrada = v;
    bus8.inicio  = 1'b1;
    step();                       // edge T accepted; now in cycle T+1
    bus8.inicio  = 1'b0;
    bus8.entrada = ~v;            // late input change must not matter
    for (int c = 1; c <= 9; c++) begin
      check({tag, "_ocupado"}, 32'(bus8.ocupado), 32'd1);
      check({tag, "_pronto"},  32'(bus8.pronto),  32'(c == 9));
      if (c < 9) check({tag, "_saida_hold"}, 32'(bus8.saida), 32'(prev8));
      else       check({tag, "_saida"},      32'(bus8.saida), 32'(esperado));
      step();
    end
    check({tag, "_idle_ocupado"}, 32'(bus8.ocupado), 32'd0);
    check({tag, "_idle_pronto"},  32'(bus8.pronto),  32'd0);
    check({tag, "_idle_saida"},   32'(bus8.saida),   32'(esperado));
    prev8 = esperado;
  endtask

  task automatic run16(input logic [15:0] v, input logic [19:0] esperado, input string tag);
    bus16.entrada = v;
    bus16.inicio  = 1'b1;
    step();
    bus16.inicio  = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      check({tag, "_ocupado"}, 32'(bus16.ocupado), 32'd1);
      check({tag, "_pronto"},  32'(bus16.pronto),  32'(c == 17));
      if (c < 17) check({tag, "_saida_hold"}, 32'(bus16.saida), 32'(prev16));
      else        check({tag, "_saida"},      32'(bus16.saida), 32'(esperado));
      step();
    end
    check({tag, "_idle_ocupado"}, 32'(bus16.ocupado), 32'd0);
    prev16 = esperado;
  endtask

  initial begin
    int npronto;

    bus8.inicio   = 1'b0;
    bus8.entrada  = '0;
    bus16.inicio  = 1'b0;
    bus16.entrada = '0;

    // Reset state
    step();
    step();
    check("rst_saida8",   32'(bus8.saida),    32'h0);
    check("rst_ocupado8", 32'(bus8.ocupado),  32'd0);
    check("rst_pronto8",  32'(bus8.pronto),   32'd0);
    check("rst_saida16",  32'(bus16.saida),   32'h0);
`ifdef CONV_BCD_APAGA_EN
    check("rst_apaga8",   32'(bus8.apaga),    32'h0);
`endif
    rst = 1'b0;
    step();

    // Full-scale 8-bit value, then back-to-back 0 / 200 / 9 (pronto 10 cycles apart)
    run8(8'd255, 12'h255, "v255");
    run8(8'd0,   12'h000, "v0");
    run8(8'd200, 12'h200, "v200");
    run8(8'd9,   12'h009, "v9");

    // inicio held high with entrada changing mid-conversion: exactly one conversion
    bus8.entrada = 8'd123;
    bus8.inicio  = 1'b1;
    step();
    npronto = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) bus8.entrada = 8'd45;
      if (c == 9) begin
        check("hold_pronto", 32'(bus8.pronto), 32'd1);
        check("hold_saida",  32'(bus8.saida),  32'h123);
        bus8.inicio = 1'b0;
      end
      if (bus8.pronto) npronto++;
      step();
    end
    check("hold_npronto", 32'(npronto),      32'd1);
    check("hold_final",   32'(bus8.saida),   32'h123);
    check("hold_ocupado", 32'(bus8.ocupado), 32'd0);
    prev8 = 12'h123;

    // Reset in the middle of a conversion of 77 after a 255 result
    run8(8'd255, 12'h255, "pre_rst");
    bus8.entrada = 8'd77;
    bus8.inicio  = 1'b1;
    step();                       // cycle T+1
    bus8.inicio  = 1'b0;
    step();
    step();
    step();                       // cycle T+4
    rst = 1'b1;
    #1;
    check("abort_saida",   32'(bus8.saida),   32'h0);
    check("abort_ocupado", 32'(bus8.ocupado), 32'd0);
    check("abort_pronto",  32'(bus8.pronto),  32'd0);
    step();
    rst = 1'b0;
    npronto = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus8.pronto) npronto++;
      step();
    end
    check("abort_npronto", 32'(npronto),    32'd0);
    check("abort_saida2",  32'(bus8.saida), 32'h0);
    prev8 = 12'h000;
    run8(8'd77, 12'h077, "v77");

    // 16-bit instance: full-scale and an interior value
    prev16 = 20'h00000;
    run16(16'd65535, 20'h65535, "w65535");
    run16(16'd1000,  20'h01000, "w1000");

`ifdef CONV_BCD_APAGA_EN
    // Leading-zero blanking mask
    run8(8'd7,   12'h007, "a7");
    check("apaga_7",   32'(bus8.apaga), 32'b110);
    run8(8'd40,  12'h040, "a40");
    check("apaga_40",  32'(bus8.apaga), 32'b100);
    run8(8'd0,   12'h000, "a0");
    check("apaga_0",   32'(bus8.apaga), 32'b110);
    run8(8'd255, 12'h255, "a255");
    check("apaga_255", 32'(bus8.apaga), 32'b000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
